// File: rtl/nes_joypad_if.sv
// CPU-side bus for the emulated NES controller ports ($4016/$4017).
`timescale 1ns/1ps
interface nes_joypad_if;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_re;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;

    modport master (output cpu_addr, cpu_we, cpu_re, cpu_din, input cpu_dout);
    modport slave  (input cpu_addr, cpu_we, cpu_re, cpu_din, output cpu_dout);
endinterface

// File: rtl/nes_joypad.sv
// Two NES controller ports fed from USB HID keycodes, presenting the
// strobe / serial-shift protocol of $4016/$4017 to the 6502 bus.
`timescale 1ns/1ps
module nes_joypad #(
    // Button order A,B,Select,Start,Up,Down,Left,Right, most significant byte first
    parameter logic [63:0] P1_KEYS = 64'h0E0D2C281A160407,
    parameter logic [63:0] P2_KEYS = 64'h373634335251504F
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   keycode,
    nes_joypad_if.slave   bus,
    output logic [7:0]    pad1,
    output logic [7:0]    pad2
);

    typedef enum logic [1:0] {SEL_NONE, SEL_P1, SEL_P2} sel_t;

    logic [31:0] kc_s1, kc_s2, kc_stable;
    logic [7:0]  sh1, sh2;
    logic        strobe;
    logic        re_d, we_d;
    sel_t        sel_d;
    logic        hit1, hit2, rd_done;
    logic        unused_din;

    function automatic logic [7:0] decode(input logic [31:0] kc, input logic [63:0] keys);
        logic [7:0] btn;
        logic [7:0] code;
        logic [7:0] key;
        btn = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            key = keys[63 - 8*i -: 8];
            for (int unsigned k = 0; k < 4; k++) begin
                code = kc[8*k +: 8];
                if (code != 8'h00 && code == key) btn[i] = 1'b1;
            end
        end
        return btn;
    endfunction

    // Address decode and read-completion (falling edge of cpu_re)
    always_comb begin
        hit1       = (bus.cpu_addr == 16'h4016);
        hit2       = (bus.cpu_addr == 16'h4017);
        rd_done    = re_d && !bus.cpu_re;
        unused_din = ^bus.cpu_din[7:1];
    end

    // Keycode resynchronisation, torn-word rejection and button decode.
    // kc_s1 == kc_s2 before the edge is the same condition as kc_s2 == kc_s3
    // after it, so the check happens one stage early without a third copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            kc_s1     <= '0;
            kc_s2     <= '0;
            kc_stable <= '0;
            pad1      <= '0;
            pad2      <= '0;
        end else begin
            kc_s1 <= keycode;
            kc_s2 <= kc_s1;
            if (kc_s1 == kc_s2) kc_stable <= kc_s2;
            pad1 <= decode(kc_stable, P1_KEYS);
            pad2 <= decode(kc_stable, P2_KEYS);
        end
    end

    // Bus edge tracking and strobe latch (first cycle of a $4016 write only)
    always_ff @(posedge clk) begin
        if (reset) begin
            we_d   <= 1'b0;
            re_d   <= 1'b0;
            sel_d  <= SEL_NONE;
            strobe <= 1'b0;
        end else begin
            we_d <= bus.cpu_we;
            re_d <= bus.cpu_re;
            if (hit1)      sel_d <= SEL_P1;
            else if (hit2) sel_d <= SEL_P2;
            else           sel_d <= SEL_NONE;
            if (bus.cpu_we && !we_d && hit1) strobe <= bus.cpu_din[0];
        end
    end

    // Shift registers: reload while strobed, otherwise shift once per completed read
    always_ff @(posedge clk) begin
        if (reset) begin
            sh1 <= '0;
            sh2 <= '0;
        end else if (strobe) begin
            sh1 <= pad1;
            sh2 <= pad2;
        end else if (rd_done) begin
            if (sel_d == SEL_P1) sh1 <= {1'b1, sh1[7:1]};
            if (sel_d == SEL_P2) sh2 <= {1'b1, sh2[7:1]};
        end
    end

    // Read data: open-bus pattern 0x40 with the current serial bit in bit 0
    always_comb begin
        bus.cpu_dout = '0;
        if (bus.cpu_re && hit1)      bus.cpu_dout = {7'b0100000, sh1[0]};
        else if (bus.cpu_re && hit2) bus.cpu_dout = {7'b0100000, sh2[0]};
    end

endmodule

// File: tb/tb_nes_joypad.sv
// Bench for nes_joypad: behavioural model with per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_nes_joypad;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] keycode;
    logic [7:0]  pad1, pad2;

    nes_joypad_if bus();

    nes_joypad #(
        .P1_KEYS(64'h0E0D2C281A160407),
        .P2_KEYS(64'h373634335251504F)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keycode(keycode),
        .bus(bus),
        .pad1(pad1),
        .pad2(pad2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    localparam logic [7:0] K1 [8] = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07};
    localparam logic [7:0] K2 [8] = '{8'h37, 8'h36, 8'h34, 8'h33, 8'h52, 8'h51, 8'h50, 8'h4F};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Which buttons of a player are held, given a keycode word
    function automatic logic [7:0] pressed(input logic [31:0] kc, input int pl);
        logic [7:0] r;
        logic [7:0] b;
        r = '0;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++) begin
                b = kc[8*k +: 8];
                if (b != 8'h00 && b == ((pl == 1) ? K1[i] : K2[i])) r[i] = 1'b1;
            end
        return r;
    endfunction

    // Reference model: pad = buttons of the newest keycode seen on two
    // consecutive samples; each port keeps a snapshot plus a count of reads.
    logic [31:0] m_h0 = '0, m_h1 = '0, m_word = '0;
    logic [7:0]  m_pad1 = '0, m_pad2 = '0, m_snap1 = '0, m_snap2 = '0;
    int          m_n1 = 0, m_n2 = 0, m_port_p = 0;
    logic        m_strobe = 1'b0, m_we_p = 1'b0, m_re_p = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_h0 = '0; m_h1 = '0; m_word = '0;
            m_pad1 = '0; m_pad2 = '0; m_snap1 = '0; m_snap2 = '0;
            m_n1 = 0; m_n2 = 0; m_port_p = 0;
            m_strobe = 1'b0; m_we_p = 1'b0; m_re_p = 1'b0;
        end else begin
            if (m_strobe) begin
                m_snap1 = m_pad1; m_snap2 = m_pad2; m_n1 = 0; m_n2 = 0;
            end else if (m_re_p && !bus.cpu_re) begin
                if (m_port_p == 1 && m_n1 < 8) m_n1++;
                if (m_port_p == 2 && m_n2 < 8) m_n2++;
            end
            if (bus.cpu_we && !m_we_p && bus.cpu_addr == 16'h4016) m_strobe = bus.cpu_din[0];
            m_we_p = bus.cpu_we;
            m_re_p = bus.cpu_re;
            m_port_p = (bus.cpu_addr == 16'h4016) ? 1 : (bus.cpu_addr == 16'h4017) ? 2 : 0;
            m_pad1 = pressed(m_word, 1);
            m_pad2 = pressed(m_word, 2);
            if (m_h0 == m_h1) m_word = m_h0;
            m_h1 = m_h0;
            m_h0 = keycode;
        end
    end

    function automatic logic serial_bit(input logic [7:0] snap, input int n);
        return (n >= 8) ? 1'b1 : snap[n];
    endfunction

    function automatic logic [7:0] exp_dout();
        if (bus.cpu_re && bus.cpu_addr == 16'h4016) return {7'b0100000, serial_bit(m_snap1, m_n1)};
        if (bus.cpu_re && bus.cpu_addr == 16'h4017) return {7'b0100000, serial_bit(m_snap2, m_n2)};
        return 8'h00;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pad1", pad1, m_pad1);
            chk("pad2", pad2, m_pad2);
            chk("cpu_dout", bus.cpu_dout, exp_dout());
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr = a; bus.cpu_din = d; bus.cpu_we = 1'b1;
        tick();
        bus.cpu_we = 1'b0;
        tick();
    endtask

    // Read lasting cyc cycles; returns the data seen in its first cycle
    task automatic rd(input logic [15:0] a, input int cyc, output logic [7:0] v);
        bus.cpu_addr = a; bus.cpu_re = 1'b1;
        v = '0;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            if (c == 0) v = bus.cpu_dout;
            @(posedge clk);
            #1;
        end
        bus.cpu_re = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rand_kc();
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
            case ($urandom_range(0, 3))
                0: w[8*k +: 8] = 8'h00;
                1: w[8*k +: 8] = K1[$urandom_range(0, 7)];
                2: w[8*k +: 8] = K2[$urandom_range(0, 7)];
                default: w[8*k +: 8] = 8'($urandom_range(0, 255));
            endcase
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [7:0] v;
    logic [7:0] exp_ser [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    logic [7:0] exp_p2 [5] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41};

    initial begin
        int found;
        logic [15:0] ra;
        reset = 1'b1;
        keycode = 32'h0000_0004;
        bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_din = '0;

        // Reset with Left held, then release
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset pad1", pad1, 8'h00);
        chk("reset dout", bus.cpu_dout, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(3);
        @(negedge clk);
        chk("pad1 before latency", pad1, 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pad1 Left latency", pad1, 8'h40);
        @(posedge clk); #1;

        // Serial readout of K + Enter
        keycode = 32'h0028_000E;
        tick(6);
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 10; i++) begin
            rd(16'h4016, 1, v);
            chk($sformatf("serial read %0d", i), v, exp_ser[i]);
        end

        // Strobe held: always returns A, follows key release
        keycode = 32'h0000_000E;
        wr(16'h4016, 8'h01);
        tick(6);
        for (int i = 0; i < 3; i++) begin
            rd(16'h4016, 1, v);
            chk($sformatf("strobe held read %0d", i), v, 8'h41);
        end
        keycode = 32'h0;
        bus.cpu_addr = 16'h4016; bus.cpu_re = 1'b1;
        found = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (found < 0 && bus.cpu_dout == 8'h40) found = n;
            @(posedge clk); #1;
        end
        bus.cpu_re = 1'b0;
        tick();
        checks++;
        if (found < 0 || found > 5) begin
            errors++;
            $display("FAIL strobe release latency: got %0d cycles required <= 5", found);
        end
        wr(16'h4016, 8'h00);

        // P2 Up with 3-cycle reads
        keycode = 32'h5200_0000;
        tick(6);
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        for (int i = 0; i < 5; i++) begin
            rd(16'h4017, 3, v);
            chk($sformatf("p2 read %0d", i), v, exp_p2[i]);
        end
        for (int i = 0; i < 2; i++) begin
            rd(16'h4016, 1, v);
            chk($sformatf("p1 idle read %0d", i), v, 8'h40);
        end

        // Torn keycode word
        for (int i = 0; i < 20; i++) begin
            keycode = (i % 2 == 0) ? 32'h0 : 32'h0707_0707;
            @(negedge clk);
            checks++;
            if (pad1 != 8'h00 && pad1 != 8'h80) begin
                errors++;
                $display("FAIL torn pad1: got %02h required 00 or 80", pad1);
            end
            @(posedge clk); #1;
        end
        keycode = 32'h0707_0707;
        tick(6);
        @(negedge clk);
        chk("torn final pad1", pad1, 8'h80);
        @(posedge clk); #1;

        // Strobe write colliding with a read completion: one shift, then reload
        keycode = 32'h0000_000D;
        tick(6);
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
        bus.cpu_addr = 16'h4016; bus.cpu_re = 1'b1;
        @(negedge clk);
        chk("collision first bit", bus.cpu_dout, 8'h40);
        @(posedge clk); #1;
        bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; bus.cpu_din = 8'h01;
        tick();
        bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
        @(negedge clk);
        chk("collision shifted bit", bus.cpu_dout, 8'h41);
        @(posedge clk); #1;
        bus.cpu_re = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            rd(16'h4016, 1, v);
            chk($sformatf("collision reload %0d", i), v, 8'h40);
        end
        wr(16'h4016, 8'h00);

        // Randomized traffic
        for (int it = 0; it < 500; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    keycode = rand_kc();
                    tick($urandom_range(1, 6));
                end
                2, 3, 4: begin
                    case ($urandom_range(0, 3))
                        0, 1: ra = 16'h4016;
                        2: ra = 16'h4017;
                        default: ra = 16'($urandom_range(16'h4010, 16'h401F));
                    endcase
                    rd(ra, $urandom_range(1, 3), v);
                end
                5, 6: wr(($urandom_range(0, 4) == 0) ? 16'h4017 : 16'h4016, 8'($urandom));
                7: begin
                    for (int i = 0; i < $urandom_range(2, 8); i++) begin
                        keycode = rand_kc();
                        tick();
                    end
                end
                8: begin
                    bus.cpu_addr = 16'h4016; bus.cpu_re = 1'b1;
                    tick();
                    bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; bus.cpu_din = 8'($urandom);
                    tick();
                    bus.cpu_we = 1'b0;
                    tick();
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.cpu_addr = ($urandom_range(0, 1) == 0) ? 16'h4016 : 16'h4017;
                        bus.cpu_re = 1'($urandom_range(0, 1));
                        reset = 1'b1;
                        tick($urandom_range(1, 2));
                        reset = 1'b0;
                        tick($urandom_range(0, 2));
                        bus.cpu_re = 1'b0;
                        tick();
                    end else begin
                        tick($urandom_range(1, 3));
                    end
                end
            endcase
        end

        bus.cpu_re = 1'b0; bus.cpu_we = 1'b0;
        tick(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_joypad.md
# nes_joypad

Emulated NES controller port pair ($4016/$4017) driven by USB keyboard keycodes. Sits directly downstream of the Nios subsystem: it consumes the 32-bit `keycode_export` word (up to four HID usage codes, one per byte), decodes it into two 8-button NES pad states, and presents the standard strobe/serial-shift protocol to the 6502 CPU bus. Runs on the CPU clock; the keycode word is resynchronised internally.

## Interface
Parameters:
- `P1_KEYS`, {0x0E,0x0D,0x2C,0x28,0x1A,0x16,0x04,0x07}: HID codes for P1 A,B,Select,Start,Up,Down,Left,Right (K,J,Space,Enter,W,S,A,D).
- `P2_KEYS`, {0x37,0x36,0x34,0x33,0x52,0x51,0x50,0x4F}: same order for P2 (. , ' ; and the arrow keys).

Ports:
- `clk`  in  1  CPU clock (`cpu_clk` domain).
- `reset`  in  1  synchronous, active-high reset.
- `keycode`  in  32  raw Nios keycode word, asynchronous to `clk`; byte k = HID code k, 0x00 = empty slot.
- `cpu_addr`  in  16  CPU address.
- `cpu_we`  in  1  CPU write strobe, level, one or more cycles per access.
- `cpu_re`  in  1  CPU read strobe, level, one or more cycles per access.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  read data; valid while `cpu_re` is high and `cpu_addr` is 0x4016/0x4017.
- `pad1`  out  8  registered P1 button vector, bit0=A … bit7=Right, active-high.
- `pad2`  out  8  registered P2 button vector.

## Operation
- Keycode sync: 2-flop synchroniser (`kc_s1`, `kc_s2`), then `kc_s3`. `kc_stable` loads `kc_s2` only when `kc_s2 == kc_s3`, which rejects torn multi-bit samples.
- Decode: button i of pad n is pressed if any of the 4 bytes of `kc_stable` equals `Pn_KEYS[i]`, with 0x00 never matching. Result is registered into `pad1`/`pad2`. Multiple simultaneous keys are OR-combined. Opposing directions are passed through unfiltered.
- Strobe: a write to 0x4016 sets `strobe <= cpu_din[0]`, on the first cycle of `cpu_we` only (rising-edge detect). Writes to 0x4017 are ignored; that address is the APU frame counter, not this block.
- Shift registers `sh1`, `sh2` (8b):
  - While `strobe`=1: reload every cycle from `pad1`/`pad2`.
  - While `strobe`=0: hold, except on a read completion.
- Read data: `cpu_dout = {7'b0100000, shN[0]}` when `cpu_re` is high and the address is 0x4016 (N=1) or 0x4017 (N=2). Otherwise `cpu_dout = 8'h00`. This is combinational from registers.
- Read completion is the falling edge of `cpu_re`, i.e. `re_d`=1 and `cpu_re`=0, using the registered address match `sel_d` (0=none, 1, 2).
  - If `strobe`=0: `shN <= {1'b1, shN[7:1]}`. After 8 reads, every further read returns 1.
  - If `strobe`=1: no shift; the reload wins.
- A multi-cycle read is counted once and presents a constant bit for its whole duration.

## Timing
- Reset values: `kc_s1..3`, `kc_stable`, `pad1`, `pad2`, `sh1`, `sh2` = 0; `strobe`=0; `re_d`=0, `we_d`=0, `sel_d`=0; `cpu_dout`=0x00.
- Keycode-to-pad latency:
  - 4 `clk` edges after `keycode` settles: s1, s2, stable (with s2==s3 at the same edge), pad.
  - A torn sample adds 1 cycle.
- `pad` to shift-register: 1 cycle while `strobe`=1.
- Strobe write: `strobe` updates at the edge ending the first `cpu_we` cycle. Reload begins the next cycle.
- Read shift: occurs at the edge where `cpu_re` is first sampled low after being high. A new read may start in that same cycle and sees the shifted value only after that edge.
- Simultaneous strobe write and read completion: the strobe write takes effect. If the new `strobe`=1, the next cycle reloads. The shift still applies in the completion cycle when the old `strobe`=0.
- Reset mid-read: all state clears. A `cpu_re` held high across the release of reset is treated as a new access (`re_d`=0) and completes with one shift.

## Test plan
- Reset: assert `reset` 2 cycles with `keycode`=0x00000004 → `pad1`=0, `cpu_dout`=0x00, `strobe`=0. Release → `pad1`=0x40 (Left) 4 cycles later.
- Serial readout: `keycode`=0x0028000E (K + Enter). Write 0x01 then 0x00 to 0x4016. Do 10 single-cycle reads of 0x4016 → bits 1,0,0,1,0,0,0,0,1,1 (`cpu_dout` 0x41,0x40,0x40,0x41,0x40×4,0x41,0x41).
- Strobe held: `strobe`=1, `keycode` P1 A pressed. Three reads of 0x4016 → all 0x41. Release the key → the next read returns 0x40 within 5 cycles.
- P2 and multi-cycle read: `keycode`=0x52000000 (Up) with strobe pulsed. Reads of 0x4017 with `cpu_re` high 3 cycles each → 0x40,0x40,0x40,0x40,0x41. 0x4016 reads stay 0x40.
- Torn word: toggle `keycode` between 0x00000000 and 0x07070707 every cycle for 20 cycles, then hold 0x07070707 → `pad1` only ever takes the values 0x00/0x80, ending at 0x80.
- Collision: a write of 0x01 to 0x4016 in the same cycle as a read completion with `strobe`=0 → exactly one shift, then reload from `pad1`.
